// File: rtl/lsb_deb_if.sv
// Internal IO bus bundle for the LEDs/switches/buttons block.
// Single-cycle strobe access; ack and read data are returned in the same cycle.
interface lsb_deb_if;
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;

    modport master (output stb, we, addr, data_in, input data_out, ack);
    modport slave  (input stb, we, addr, data_in, output data_out, ack);
endinterface

// File: rtl/lsb_deb.sv
// LEDs/switches/buttons block: synchronised and debounced inputs, sticky
// button events with an interrupt, and an eight-digit seven-segment display.
module lsb_deb #(
    parameter int NUM_BTN    = 4,
    parameter int NUM_SWI    = 18,
    parameter int NUM_LED_G  = 9,
    parameter int NUM_LED_R  = 18,
    parameter int DEB_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lsb_deb_if.slave             bus,
    output logic                 irq,
    input  logic [NUM_LED_R-1:0] led_r_in,
    input  logic [NUM_BTN-1:0]   btn_in_n,
    input  logic [NUM_SWI-1:0]   swi_in,
    output logic [NUM_LED_G-1:0] led_g,
    output logic [NUM_LED_R-1:0] led_r,
    output logic [55:0]          hex_n,
    output logic [NUM_BTN-1:0]   btn,
    output logic [NUM_SWI-1:0]   swi
);
    localparam int NUM_IN = NUM_BTN + NUM_SWI;
    localparam int CNT_W  = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    // Buttons sit in the low bits of the combined input vector and idle high.
    localparam logic [NUM_IN-1:0] BTN_MASK = NUM_IN'((1 << NUM_BTN) - 1);

    logic [NUM_IN-1:0]            sync1_d, sync1_q, sync2_q, synced;
    logic [NUM_IN-1:0]            stable_d, stable_q;
    logic [NUM_IN-1:0][CNT_W-1:0] cnt_d, cnt_q;
    logic [NUM_BTN-1:0]           btn_prev_q, btn_rise, btn_fall;
    logic [NUM_BTN-1:0]           press_d, press_q, release_d, release_q;
    logic [NUM_BTN-1:0]           clr_press, clr_release;
    logic [NUM_BTN-1:0]           irq_en_d, irq_en_q;
    logic [NUM_LED_G-1:0]         led_g_d, led_g_q;
    logic [NUM_LED_R-1:0]         led_r_q;
    logic [31:0]                  digits_d, digits_q;
    logic [7:0]                   blank_d, blank_q;
    logic                         irq_d, irq_q;
    logic                         wr, rd;
    logic [31:0]                  rdata;
    logic                         unused_data_in;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign sync1_d  = {swi_in, btn_in_n};
    assign synced   = sync2_q ^ BTN_MASK;
    assign btn      = stable_q[NUM_BTN-1:0];
    assign swi      = stable_q[NUM_IN-1:NUM_BTN];
    assign btn_rise = btn & ~btn_prev_q;
    assign btn_fall = ~btn & btn_prev_q;
    assign wr       = bus.stb & bus.we;
    assign rd       = bus.stb & ~bus.we;
    assign unused_data_in = ^bus.data_in;

    // Debounce: any sample matching the stable level restarts the count.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (synced[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) stable_d[i] = synced[i];
                else                      cnt_d[i]    = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        led_g_d     = led_g_q;
        digits_d    = digits_q;
        blank_d     = blank_q;
        irq_en_d    = irq_en_q;
        clr_press   = '0;
        clr_release = '0;
        if (wr) begin
            case (bus.addr)
                2'd0: led_g_d = bus.data_in[NUM_LED_G-1:0];
                2'd1: begin
                    clr_press   = bus.data_in[NUM_BTN-1:0];
                    clr_release = bus.data_in[8 +: NUM_BTN];
                end
                2'd2: digits_d = bus.data_in;
                2'd3: begin
                    blank_d  = bus.data_in[7:0];
                    irq_en_d = bus.data_in[8 +: NUM_BTN];
                end
            endcase
        end
        // A new edge outranks a write-1-to-clear in the same cycle.
        press_d   = (press_q & ~clr_press) | btn_rise;
        release_d = (release_q & ~clr_release) | btn_fall;
        irq_d     = |(press_q & irq_en_q);
    end

    always_comb begin
        rdata = '0;
        case (bus.addr)
            2'd0: begin
                rdata[NUM_SWI-1:0]   = swi;
                rdata[24 +: NUM_BTN] = btn;
            end
            2'd1: begin
                rdata[0 +: NUM_BTN] = press_q;
                rdata[8 +: NUM_BTN] = release_q;
            end
            2'd2: rdata = digits_q;
            2'd3: begin
                rdata[7:0]          = blank_q;
                rdata[8 +: NUM_BTN] = irq_en_q;
            end
        endcase
    end

    always_comb begin
        hex_n = '1;
        for (int k = 0; k < 8; k++) begin
            if (!blank_q[k]) hex_n[7*k +: 7] = seg7(digits_q[4*k +: 4]);
        end
    end

    assign bus.ack      = bus.stb;
    assign bus.data_out = rd ? rdata : '0;
    assign led_g        = led_g_q;
    assign led_r        = led_r_q;
    assign irq          = irq_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (!rst_n) begin
            sync1_q    <= BTN_MASK;
            sync2_q    <= BTN_MASK;
            stable_q   <= '0;
            cnt_q      <= '0;
            btn_prev_q <= '0;
            press_q    <= '0;
            release_q  <= '0;
            irq_en_q   <= '0;
            led_g_q    <= '0;
            led_r_q    <= '0;
            digits_q   <= '0;
            blank_q    <= 8'hFF;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            btn_prev_q <= btn;
            press_q    <= press_d;
            release_q  <= release_d;
            irq_en_q   <= irq_en_d;
            led_g_q    <= led_g_d;
            led_r_q    <= led_r_in;
            digits_q   <= digits_d;
            blank_q    <= blank_d;
            irq_q      <= irq_d;
        end
    end
endmodule

// File: tb/tb_lsb_deb.sv
// Self-checking bench for lsb_deb with a four-cycle debounce period.
`timescale 1ns/1ps
module tb_lsb_deb;
    localparam int NUM_BTN   = 4;
    localparam int NUM_SWI   = 18;
    localparam int NUM_LED_G = 9;
    localparam int NUM_LED_R = 18;
    localparam int DEB       = 4;
    localparam int NUM_IN    = NUM_BTN + NUM_SWI;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 irq;
    logic [NUM_LED_R-1:0] led_r_in = '0;
    logic [NUM_LED_R-1:0] led_r;
    logic [NUM_BTN-1:0]   btn_in_n = '1;
    logic [NUM_BTN-1:0]   btn;
    logic [NUM_SWI-1:0]   swi_in = '0;
    logic [NUM_SWI-1:0]   swi;
    logic [NUM_LED_G-1:0] led_g;
    logic [55:0]          hex_n;
    int                   n_checks = 0;
    int                   n_fail = 0;
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    lsb_deb_if bus ();

    lsb_deb #(
        .NUM_BTN(NUM_BTN), .NUM_SWI(NUM_SWI), .NUM_LED_G(NUM_LED_G),
        .NUM_LED_R(NUM_LED_R), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .irq(irq), .led_r_in(led_r_in),
        .btn_in_n(btn_in_n), .swi_in(swi_in), .led_g(led_g), .led_r(led_r),
        .hex_n(hex_n), .btn(btn), .swi(swi)
    );

    always #50 clk = ~clk;

    function automatic logic [55:0] hex_model(input logic [31:0] digits, input logic [7:0] blank);
        logic [55:0] h;
        for (int k = 0; k < 8; k++) h[7*k +: 7] = blank[k] ? 7'h7F : seg_tab[digits[4*k +: 4]];
        return h;
    endfunction

    // All bus tasks start and end at a falling edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.stb = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_in = d;
        @(negedge clk);
        bus.stb = 1'b0; bus.we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.stb = 1'b1; bus.we = 1'b0; bus.addr = a;
        #1;
        d = bus.data_out;
        bus.stb = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_rd [4];
        logic [31:0] got;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; exp_rd[2] = 32'h0; exp_rd[3] = 32'hFF;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), got);
            n_checks++;
            if (got !== exp_rd[a]) begin
                n_fail++; $display("FAIL reset_read_addr%0d: got %h expected %h", a, got, exp_rd[a]);
            end
        end
        n_checks++;
        if (hex_n !== {56{1'b1}}) begin n_fail++; $display("FAIL reset_hex: got %h expected all ones", hex_n); end
        n_checks++;
        if ({irq, led_g, led_r, btn, swi} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: irq=%b led_g=%h led_r=%h btn=%h swi=%h expected 0", irq, led_g, led_r, btn, swi);
        end
        bus.stb = 1'b1; bus.we = 1'b0; bus.addr = 2'd3; #1;
        n_checks++;
        if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL ack_high: got %b expected 1", bus.ack); end
        bus.stb = 1'b0; #1;
        n_checks++;
        if ({bus.ack, bus.data_out} !== 33'h0) begin
            n_fail++; $display("FAIL idle_bus: ack=%b data_out=%h expected 0", bus.ack, bus.data_out);
        end
    endtask

    task automatic test_led();
        logic [NUM_LED_R-1:0] v;
        logic [31:0]          got;
        v = NUM_LED_R'($urandom) | NUM_LED_R'(1);
        led_r_in = v;
        #1;
        n_checks++;
        if (led_r !== '0) begin n_fail++; $display("FAIL led_r_before_edge: got %h expected 0", led_r); end
        @(negedge clk);
        n_checks++;
        if (led_r !== v) begin n_fail++; $display("FAIL led_r_follow: got %h expected %h", led_r, v); end
        bus.stb = 1'b1; bus.we = 1'b1; bus.addr = 2'd0; bus.data_in = 32'hFFFF_FFFF; #1;
        n_checks++;
        if ({bus.ack, bus.data_out} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL write_cycle_bus: ack=%b data_out=%h expected 1/0", bus.ack, bus.data_out);
        end
        @(negedge clk);
        bus.stb = 1'b0; bus.we = 1'b0;
        n_checks++;
        if (led_g !== {NUM_LED_G{1'b1}}) begin n_fail++; $display("FAIL led_g_all: got %h expected 1ff", led_g); end
        bus_read(2'd0, got);
        n_checks++;
        if (got !== 32'h0) begin n_fail++; $display("FAIL addr0_after_write: got %h expected 0", got); end
        bus_write(2'd0, 32'h0000_00A5);
        n_checks++;
        if (led_g !== 9'h0A5) begin n_fail++; $display("FAIL led_g_a5: got %h expected 0a5", led_g); end
    endtask

    task automatic test_btn_debounce();
        logic [31:0] got;
        btn_in_n[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (btn[0] !== (k == 6)) begin
                n_fail++; $display("FAIL btn_press_latency cycle %0d: got %b expected %b", k, btn[0], (k == 6));
            end
        end
        bus_read(2'd1, got);
        n_checks++;
        if (got !== 32'h0) begin n_fail++; $display("FAIL press_ev_early: got %h expected 0", got); end
        @(negedge clk);
        bus_read(2'd1, got);
        n_checks++;
        if (got !== 32'h1) begin n_fail++; $display("FAIL press_ev: got %h expected 1", got); end
        btn_in_n[0] = 1'b1;
        repeat (7) @(negedge clk);
        bus_read(2'd1, got);
        n_checks++;
        if (got !== 32'h101 || btn !== '0) begin
            n_fail++; $display("FAIL release_ev: got %h btn=%h expected 101 btn=0", got, btn);
        end
        bus_write(2'd1, 32'h101);
        bus_read(2'd1, got);
        n_checks++;
        if (got !== 32'h0) begin n_fail++; $display("FAIL w1c_clear: got %h expected 0", got); end
        btn_in_n[0] = 1'b0;
        repeat (3) @(negedge clk);
        btn_in_n[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (btn[0] !== 1'b0) begin n_fail++; $display("FAIL short_pulse cycle %0d: got %b expected 0", k, btn[0]); end
        end
        bus_read(2'd1, got);
        n_checks++;
        if (got !== 32'h0) begin n_fail++; $display("FAIL short_pulse_event: got %h expected 0", got); end
    endtask

    task automatic test_switch_bounce();
        logic [31:0] got;
        for (int c = 0; c < 20; c++) begin
            swi_in[5] = ((c / 2) % 2 == 0);
            @(negedge clk);
            n_checks++;
            if (swi[5] !== 1'b0) begin n_fail++; $display("FAIL swi_bounce cycle %0d: got %b expected 0", c, swi[5]); end
        end
        swi_in[5] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (swi[5] !== (k == 6)) begin
                n_fail++; $display("FAIL swi_hold_latency cycle %0d: got %b expected %b", k, swi[5], (k == 6));
            end
        end
        bus_read(2'd0, got);
        n_checks++;
        if (got !== 32'h20) begin n_fail++; $display("FAIL addr0_swi5: got %h expected 20", got); end
    endtask

    task automatic test_hex();
        logic [31:0] got, d;
        logic [7:0]  b;
        bus_write(2'd2, 32'h89AB_CDEF);
        bus_write(2'd3, 32'h0);
        n_checks++;
        if (hex_n[6:0] !== 7'h0E || hex_n[55:49] !== 7'h00) begin
            n_fail++; $display("FAIL hex_digits_0_7: got %h/%h expected 0e/00", hex_n[6:0], hex_n[55:49]);
        end
        n_checks++;
        if (hex_n !== hex_model(32'h89AB_CDEF, 8'h00)) begin
            n_fail++; $display("FAIL hex_all: got %h expected %h", hex_n, hex_model(32'h89AB_CDEF, 8'h00));
        end
        bus_read(2'd2, got);
        n_checks++;
        if (got !== 32'h89AB_CDEF) begin n_fail++; $display("FAIL digits_readback: got %h expected 89abcdef", got); end
        bus_write(2'd3, 32'h1);
        n_checks++;
        if (hex_n !== hex_model(32'h89AB_CDEF, 8'h01) || hex_n[6:0] !== 7'h7F) begin
            n_fail++; $display("FAIL hex_blank0: got %h expected %h", hex_n, hex_model(32'h89AB_CDEF, 8'h01));
        end
        for (int r = 0; r < 6; r++) begin
            d = $urandom;
            b = 8'($urandom_range(255));
            bus_write(2'd2, d);
            bus_write(2'd3, {24'h0, b});
            bus_read(2'd3, got);
            n_checks++;
            if (hex_n !== hex_model(d, b) || got !== {24'h0, b}) begin
                n_fail++; $display("FAIL hex_random %0d: hex %h ctrl %h expected %h ctrl %h", r, hex_n, got, hex_model(d, b), b);
            end
        end
        bus_write(2'd3, 32'h0000_FF01);
        bus_read(2'd3, got);
        n_checks++;
        if (got !== 32'h0000_0F01) begin n_fail++; $display("FAIL irq_en_width: got %h expected 00000f01", got); end
        bus_write(2'd3, 32'h0);
    endtask

    task automatic test_irq();
        logic [31:0] got;
        logic        seen;
        bus_write(2'd1, 32'hFFFF);
        bus_write(2'd3, 32'h0000_0100);
        btn_in_n[0] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = btn[0];
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL irq_btn_wait: got no press within 20 cycles expected press"); end
        bus_read(2'd1, got);
        n_checks++;
        if (got !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL irq_stage0: ev %h irq %b expected 0/0", got, irq); end
        @(negedge clk);
        bus_read(2'd1, got);
        n_checks++;
        if (got !== 32'h1 || irq !== 1'b0) begin n_fail++; $display("FAIL irq_stage1: ev %h irq %b expected 1/0", got, irq); end
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_raise: got %b expected 1", irq); end
        btn_in_n[0] = 1'b1;
        repeat (8) @(negedge clk);
        bus_write(2'd1, 32'h101);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_registered: got %b expected 1", irq); end
        @(negedge clk);
        bus_read(2'd1, got);
        n_checks++;
        if (irq !== 1'b0 || got !== 32'h0) begin n_fail++; $display("FAIL irq_clear: irq %b ev %h expected 0/0", irq, got); end
        btn_in_n[0] = 1'b0;
        repeat (6) @(negedge clk);
        bus_read(2'd1, got);
        n_checks++;
        if (btn[0] !== 1'b1 || got !== 32'h0) begin n_fail++; $display("FAIL coincide_setup: btn %b ev %h expected 1/0", btn[0], got); end
        bus_write(2'd1, 32'h1);
        bus_read(2'd1, got);
        n_checks++;
        if (got !== 32'h1) begin n_fail++; $display("FAIL set_beats_clear: got %h expected 1", got); end
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_coincide: got %b expected 1", irq); end
        btn_in_n[0] = 1'b1;
        repeat (8) @(negedge clk);
        bus_write(2'd1, 32'hFFFF);
        bus_write(2'd3, 32'h0);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_final: got %b expected 0", irq); end
    endtask

    task automatic test_reset_mid();
        swi_in[3] = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (swi[3] !== 1'b0) begin n_fail++; $display("FAIL mid_count_swi: got %b expected 0", swi[3]); end
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (swi[3] !== (k == 6)) begin
                n_fail++; $display("FAIL reset_mid_latency cycle %0d: got %b expected %b", k, swi[3], (k == 6));
            end
        end
        n_checks++;
        if (led_g !== '0 || hex_n !== {56{1'b1}}) begin
            n_fail++; $display("FAIL reset_mid_regs: led_g %h hex %h expected 0/all ones", led_g, hex_n);
        end
    endtask

    task automatic test_random();
        logic [NUM_IN-1:0]    hist [$];
        logic [NUM_IN-1:0]    cur, stable_m;
        logic [NUM_BTN-1:0]   btn_m, btn_prev_m, press_m, rel_m, en_m;
        logic [NUM_LED_R-1:0] led_exp;
        logic [7:0]           en8;
        logic [31:0]          got, exp;
        logic                 same, irq_m;
        swi_in = '0; btn_in_n = '1; led_r_in = '0;
        repeat (8) @(negedge clk);
        do_reset();
        en8 = 8'($urandom_range(255)) | 8'h01;
        en_m = en8[NUM_BTN-1:0];
        bus_write(2'd3, {16'h0, en8, 8'h00});
        hist = {};
        repeat (DEB + 2) hist.push_back('0);
        cur = '0; stable_m = '0; btn_m = '0; btn_prev_m = '0; press_m = '0; rel_m = '0; irq_m = 1'b0;
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < NUM_IN; i++) if ($urandom_range(4) == 0) cur[i] = ~cur[i];
            btn_in_n = ~cur[NUM_BTN-1:0];
            swi_in   = cur[NUM_IN-1:NUM_BTN];
            led_exp  = NUM_LED_R'($urandom);
            led_r_in = led_exp;
            hist.push_front(cur);
            void'(hist.pop_back());
            @(negedge clk);
            irq_m      = |(press_m & en_m);
            press_m    = press_m | (btn_m & ~btn_prev_m);
            rel_m      = rel_m | (~btn_m & btn_prev_m);
            btn_prev_m = btn_m;
            // A level is taken once the synchronised input held it for DEB edges.
            for (int i = 0; i < NUM_IN; i++) begin
                same = 1'b1;
                for (int j = 3; j <= DEB + 1; j++) if (hist[j][i] !== hist[2][i]) same = 1'b0;
                if (same && hist[2][i] !== stable_m[i]) stable_m[i] = hist[2][i];
            end
            btn_m = stable_m[NUM_BTN-1:0];
            n_checks++;
            if ({swi, btn} !== stable_m) begin
                n_fail++; $display("FAIL rand_debounce t=%0d: got %h expected %h", t, {swi, btn}, stable_m);
            end
            n_checks++;
            if (irq !== irq_m) begin n_fail++; $display("FAIL rand_irq t=%0d: got %b expected %b", t, irq, irq_m); end
            n_checks++;
            if (led_r !== led_exp) begin n_fail++; $display("FAIL rand_led_r t=%0d: got %h expected %h", t, led_r, led_exp); end
        end
        exp = '0;
        exp[NUM_BTN-1:0]   = press_m;
        exp[8 +: NUM_BTN]  = rel_m;
        bus_read(2'd1, got);
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL rand_events: got %h expected %h", got, exp); end
        exp = '0;
        exp[NUM_SWI-1:0]    = stable_m[NUM_IN-1:NUM_BTN];
        exp[24 +: NUM_BTN]  = stable_m[NUM_BTN-1:0];
        bus_read(2'd0, got);
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL rand_addr0: got %h expected %h", got, exp); end
    endtask

    initial begin
        bus.stb = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.data_in = 32'h0;
        @(negedge clk);
        test_reset();
        test_led();
        test_btn_debounce();
        test_switch_bounce();
        test_hex();
        test_irq();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "time limit reached");
    end
endmodule
